// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, optional parity, 1-2 stop bits, 3-sample
// majority vote at mid-bit, and a first-word fall-through output FIFO.
module uart_rx_cfg #(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD_RATE  = 19200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_par_err,
   output logic                 rx_frm_err,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
   localparam int unsigned TW  = $clog2(DIV);
   localparam int unsigned BW  = $clog2(DATA_BITS);
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned EW  = DATA_BITS + 2;

   localparam logic [TW-1:0] T_LO  = TW'(DIV / 2 - 1);
   localparam logic [TW-1:0] T_MID = TW'(DIV / 2);
   localparam logic [TW-1:0] T_HI  = TW'(DIV / 2 + 1);
   localparam logic [TW-1:0] T_MAX = TW'(DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StPush} state_e;

   state_e                 state_q, state_d;
   logic                   rx_meta, rxs;
   logic [TW-1:0]          timer_q, timer_d;
   logic [1:0]             samp_q;
   logic [BW-1:0]          bit_idx_q, bit_idx_d;
   logic                   stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   par_err_q, par_err_d;
   logic                   frm_err_q, frm_err_d;
   logic                   armed_q, armed_d;
   logic                   mid, maj;

   // Decision point is M+1, the first cycle all three samples are available.
   assign mid  = (timer_q == T_HI);
   assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
   assign busy = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rxs        <= 1'b1;
         state_q    <= StIdle;
         timer_q    <= '0;
         samp_q     <= 2'b11;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shreg_q    <= '0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         armed_q    <= 1'b1;
      end else begin
         rx_meta    <= rx;
         rxs        <= rx_meta;
         state_q    <= state_d;
         timer_q    <= timer_d;
         if (timer_q == T_LO) samp_q[0] <= rxs;
         if (timer_q == T_MID) samp_q[1] <= rxs;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shreg_q    <= shreg_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
         armed_q    <= armed_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = (timer_q == T_MAX) ? '0 : timer_q + 1'b1;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shreg_d    = shreg_q;
      par_err_d  = par_err_q;
      frm_err_d  = frm_err_q;
      armed_d    = armed_q;
      unique case (state_q)
         StIdle: begin
            timer_d   = '0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
            if (rxs) armed_d = 1'b1;
            else if (armed_q) state_d = StStart;
         end
         StStart: begin
            if (mid) begin
               if (!maj) begin
                  bit_idx_d = '0;
                  state_d   = StData;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            if (mid) begin
               shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
               if (bit_idx_q == LAST_BIT) begin
                  stop_idx_d = 1'b0;
                  state_d    = (PARITY != 0) ? StParity : StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         StParity: begin
            if (mid) begin
               par_err_d = ((^shreg_q) ^ maj) != (PARITY == 1);
               state_d   = StStop;
            end
         end
         StStop: begin
            if (mid) begin
               if (!maj) frm_err_d = 1'b1;
               if (stop_idx_q == 1'(STOP_BITS - 1)) state_d = StPush;
               else stop_idx_d = 1'b1;
            end
         end
         StPush: begin
            // A framing error disarms so a held-low break cannot retrigger a start.
            armed_d = !frm_err_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          push, pop, full, wr_en;
   logic [EW-1:0] head;

   assign push     = (state_q == StPush);
   assign rx_valid = (cnt_q != '0);
   assign pop      = rx_valid && rx_ready;
   assign full     = (cnt_q == CW'(FIFO_DEPTH));
   assign wr_en    = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_q] <= {frm_err_q, par_err_q, shreg_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         if (wr_en && !pop) cnt_q <= cnt_q + 1'b1;
         else if (!wr_en && pop) cnt_q <= cnt_q - 1'b1;
         overrun <= push && full && !pop;
      end
   end

   assign head       = mem[rd_q];
   assign rx_data    = rx_valid ? head[DATA_BITS-1:0] : '0;
   assign rx_par_err = rx_valid ? head[DATA_BITS] : 1'b0;
   assign rx_frm_err = rx_valid ? head[DATA_BITS+1] : 1'b0;

endmodule
